// File: rtl/inst_rom_arbiter.sv
// Two-requester arbiter in front of a combinational instruction ROM.
// Port 0 has fixed priority; a starvation counter forces port 1 through after WAIT_MAX denials.
module inst_rom_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAIT_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              rready0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              rvalid1,
    input  logic              rready1,
    output logic [DATA_W-1:0] rdata,
    output logic              rerr,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

    logic              valid_a, id_a, err_a;
    logic [ADDR_W-1:0] addr_a;
    logic              valid_b, id_b, err_b;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  cnt;

    logic              stall, accept, force1, winner;
    logic [ADDR_W-1:0] win_addr;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        stall    = 1'b0;
        accept   = 1'b1;
        force1   = 1'b0;
        winner   = 1'b0;
        win_addr = addr0;
        gnt0     = 1'b0;
        gnt1     = 1'b0;

        stall    = valid_b && (id_b ? !rready1 : !rready0);
        accept   = !stall;
        force1   = (cnt == CNT_MAX) && req1;
        winner   = force1 || (req1 && !req0);
        win_addr = winner ? addr1 : addr0;
        // Grants are gated by rst so nothing is accepted while reset is held.
        gnt0     = rst && accept && req0 && !winner;
        gnt1     = rst && accept && req1 && winner;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_a <= 1'b0;
            id_a    <= 1'b0;
            addr_a  <= '0;
            err_a   <= 1'b0;
        end else if (accept) begin
            valid_a <= gnt0 || gnt1;
            if (gnt0 || gnt1) begin
                id_a   <= gnt1;
                addr_a <= win_addr;
                err_a  <= (win_addr[1:0] != 2'b00);
            end
        end
    end

    // Misaligned fetches never reach the ROM.
    assign rom_ce   = valid_a && !err_a;
    assign rom_addr = rom_ce ? addr_a : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_b <= 1'b0;
            id_b    <= 1'b0;
            err_b   <= 1'b0;
            rdata_q <= '0;
        end else if (accept) begin
            valid_b <= valid_a;
            id_b    <= id_a;
            err_b   <= err_a;
            rdata_q <= rom_ce ? rom_inst : '0;
        end
    end

    // Counter holds while stalled; it only counts cycles where port 1 could have won.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (accept) begin
            if (gnt1 || !req1)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 4'd1;
        end
    end

    assign rvalid0 = valid_b && !id_b;
    assign rvalid1 = valid_b && id_b;
    assign rdata   = rdata_q;
    assign rerr    = err_b;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Self-checking bench for inst_rom_arbiter: a negedge monitor scoreboards every grant
// against the response it produces; scenario tasks check timing, stalls and reset.
module tb_inst_rom_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct {
        logic              id;
        logic              err;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0, req1, rready0, rready1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic              gnt0, gnt1, rvalid0, rvalid1, rerr, rom_ce;
    logic [DATA_W-1:0] rdata, rom_inst;
    logic [ADDR_W-1:0] rom_addr;

    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b1;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign rom_inst = rom_ce ? rom_fn(rom_addr) : 32'hDEAD_BEEF;

    inst_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rready0(rready0),
        .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rready1(rready1),
        .rdata(rdata), .rerr(rerr), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
    );

    // Scoreboard: consume responses handshaken this cycle, then record new grants.
    always @(negedge clk) begin
        if (mon_en && rst) begin
            if (rvalid0 && rvalid1) begin
                checks++; errors++;
                $display("FAIL dual_rvalid: got both rvalid0 and rvalid1 high, expected at most one");
            end
            if ((rvalid0 && rready0) || (rvalid1 && rready1)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: got response id=%0d with nothing outstanding", rvalid1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (rvalid1 !== e.id || rerr !== e.err || rdata !== e.data) begin
                        errors++;
                        $display("FAIL resp: got id=%0d err=%0d data=%h expected id=%0d err=%0d data=%h",
                                 rvalid1, rerr, rdata, e.id, e.err, e.data);
                    end
                end
            end
            if (gnt0 || gnt1) begin
                exp_t n;
                logic [ADDR_W-1:0] a;
                a      = gnt1 ? addr1 : addr0;
                n.id   = gnt1;
                n.err  = (a[1:0] != 2'b00);
                n.data = n.err ? '0 : rom_fn(a);
                exp_q.push_back(n);
            end
        end
    end

    task automatic idle(input int n);
        req0 = 1'b0; req1 = 1'b0; rready0 = 1'b1; rready1 = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1; addr0 = 32'h4; addr1 = 32'h8;
        rready0 = 1'b1; rready1 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++;
            $display("FAIL reset_gnt: got gnt0=%b gnt1=%b expected 0 0", gnt0, gnt1); end
        checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin errors++;
            $display("FAIL reset_rvalid: got %b %b expected 0 0", rvalid0, rvalid1); end
        checks++; if (rom_ce !== 1'b0 || rom_addr !== '0) begin errors++;
            $display("FAIL reset_rom: got ce=%b addr=%h expected 0 0", rom_ce, rom_addr); end
        checks++; if (rdata !== '0 || rerr !== 1'b0) begin errors++;
            $display("FAIL reset_rdata: got rdata=%h rerr=%b expected 0 0", rdata, rerr); end
        req0 = 1'b0; req1 = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_port0_stream;
        logic [5:0] rv_seen, ce_seen;
        rv_seen = '0; ce_seen = '0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            req0 = (c < 3); addr0 = 32'(4 * c);
            @(negedge clk);
            rv_seen[c] = rvalid0;
            ce_seen[c] = rom_ce;
            if (c < 3) begin
                checks++;
                if (gnt0 !== 1'b1) begin errors++;
                    $display("FAIL stream_gnt0[%0d]: got %b expected 1", c, gnt0); end
            end
        end
        checks++; if (rv_seen !== 6'b011100) begin errors++;
            $display("FAIL stream_latency: got rvalid0 pattern %b expected 011100", rv_seen); end
        checks++; if (ce_seen !== 6'b001110) begin errors++;
            $display("FAIL stream_rom_ce: got rom_ce pattern %b expected 001110", ce_seen); end
        idle(3);
        checks++; if (exp_q.size() != 0) begin errors++;
            $display("FAIL stream_drain: got %0d outstanding expected 0", exp_q.size()); end
    endtask

    task automatic test_starvation;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            req0 = 1'b1; req1 = 1'b1; addr0 = 32'h100; addr1 = 32'h200;
            rready0 = 1'b1; rready1 = 1'b1;
            @(negedge clk);
            checks++;
            if (gnt1 !== (c % 5 == 4) || gnt0 !== (c % 5 != 4)) begin errors++;
                $display("FAIL starve_pattern[%0d]: got gnt0=%b gnt1=%b expected gnt1=%0d",
                         c, gnt0, gnt1, (c % 5 == 4)); end
        end
        @(posedge clk); #1;
        idle(4);
        checks++; if (exp_q.size() != 0) begin errors++;
            $display("FAIL starve_drain: got %0d outstanding expected 0", exp_q.size()); end
    endtask

    task automatic test_misaligned;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            req0 = (c == 0); addr0 = 32'h6;
            @(negedge clk);
            if (c == 1) begin
                checks++; if (rom_ce !== 1'b0) begin errors++;
                    $display("FAIL misalign_ce: got rom_ce=%b expected 0", rom_ce); end
            end
            if (c == 2) begin
                checks++;
                if (rvalid0 !== 1'b1 || rerr !== 1'b1 || rdata !== '0) begin errors++;
                    $display("FAIL misalign_resp: got rvalid0=%b rerr=%b rdata=%h expected 1 1 0",
                             rvalid0, rerr, rdata); end
            end
        end
        idle(3);
    endtask

    task automatic test_backpressure;
        int idx = 0;
        logic [DATA_W-1:0] snap_data;
        logic [ADDR_W-1:0] snap_addr;
        snap_data = '0; snap_addr = '0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            req0 = (idx < 5); addr0 = 32'h40 + 32'(4 * idx);
            rready0 = !(c >= 2 && c <= 4);
            @(negedge clk);
            if (c == 2) begin snap_data = rdata; snap_addr = rom_addr; end
            if (c >= 2 && c <= 4) begin
                checks++;
                if (gnt0 !== 1'b0 || rvalid0 !== 1'b1 || rdata !== snap_data ||
                    rom_addr !== snap_addr || rom_addr !== 32'h44) begin errors++;
                    $display("FAIL stall_hold[%0d]: got gnt0=%b rvalid0=%b rdata=%h rom_addr=%h expected 0 1 %h 00000044",
                             c, gnt0, rvalid0, rdata, rom_addr, snap_data); end
            end
            if (gnt0) idx++;
        end
        checks++; if (idx != 5) begin errors++;
            $display("FAIL stall_grants: got %0d grants expected 5", idx); end
        idle(3);
        checks++; if (exp_q.size() != 0) begin errors++;
            $display("FAIL stall_drain: got %0d outstanding expected 0", exp_q.size()); end
    endtask

    task automatic test_mixed;
        int  idx = 0;
        bit  p1_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            req1 = !p1_done; addr1 = 32'h80;
            req0 = (c >= 2) && (idx < 2); addr0 = 32'h84 + 32'(4 * idx);
            rready0 = 1'b1; rready1 = (c >= 5);
            @(negedge clk);
            if (c >= 2 && c <= 4) begin
                checks++;
                if (gnt0 !== 1'b0 || rvalid1 !== 1'b1) begin errors++;
                    $display("FAIL mixed_block[%0d]: got gnt0=%b rvalid1=%b expected 0 1", c, gnt0, rvalid1); end
            end
            if (c == 5) begin
                checks++;
                if (gnt0 !== 1'b1) begin errors++;
                    $display("FAIL mixed_release: got gnt0=%b expected 1", gnt0); end
            end
            if (gnt1) p1_done = 1'b1;
            if (gnt0) idx++;
        end
        idle(3);
        checks++; if (exp_q.size() != 0) begin errors++;
            $display("FAIL mixed_drain: got %0d outstanding expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_midflight;
        mon_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            req0 = (c == 0); addr0 = 32'h300;
            req1 = (c == 1); addr1 = 32'h304;
            rready0 = 1'b1; rready1 = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (rvalid0 !== 1'b1 || rom_ce !== 1'b1) begin errors++;
            $display("FAIL midflight_setup: got rvalid0=%b rom_ce=%b expected 1 1", rvalid0, rom_ce); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || rom_ce !== 1'b0 || rdata !== '0) begin errors++;
            $display("FAIL async_reset: got rvalid0=%b rvalid1=%b rom_ce=%b rdata=%h expected all 0",
                     rvalid0, rvalid1, rom_ce, rdata); end
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin errors++;
                $display("FAIL stale_resp[%0d]: got rvalid0=%b rvalid1=%b expected 0 0", c, rvalid0, rvalid1); end
        end
        exp_q.delete();
        mon_en = 1'b1;
    endtask

    initial begin
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        rready0 = 1'b1; rready1 = 1'b1;
        test_reset;
        test_port0_stream;
        test_starvation;
        test_misaligned;
        test_backpressure;
        test_mixed;
        test_reset_midflight;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
